// File: rtl/oam_dma_ctrl.sv
// OAM DMA sequencer: copies LEN bytes from a source page into object attribute
// memory at DST_BASE, owning the shared bus and holding the CPU off via cpu_grant.
module oam_dma_ctrl #(
   parameter int unsigned LEN      = 160,
   parameter logic [15:0] DST_BASE = 16'hFE00
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [7:0]  src_page,
   output logic        cpu_grant,
   output logic        busy,
   output logic        done,
   output logic [15:0] dma_addr,
   output logic        addr_oe,
   input  logic [7:0]  dma_rdata,
   output logic [7:0]  dma_wdata,
   output logic        data_oe,
   output logic        mem_cs,
   output logic        mem_oe,
   output logic        mem_we
);

   typedef enum logic [2:0] {StIdle, StArb, StRdA, StRdB, StWrA, StWrB, StDone} state_e;

   state_e      state_q, state_d;
   logic [7:0]  count_q, count_d;
   logic [7:0]  page_q, page_d;
   // A start seen mid-byte is parked here until the byte's write completes.
   logic        pend_q, pend_d;
   logic [7:0]  pend_page_q, pend_page_d;

   logic        rd_d, wr_d;
   logic [15:0] addr_d;

   // Echo region 0xE0..0xFF mirrors 0xC0..0xDF.
   function automatic logic [7:0] eff_page(input logic [7:0] p);
      return (p >= 8'hE0) ? (p - 8'h20) : p;
   endfunction

   // Next-state, count, page and pending-restart selection
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      page_d      = page_q;
      pend_d      = pend_q;
      pend_page_d = pend_page_q;
      if (start && (state_q inside {StArb, StRdA, StRdB, StWrA})) begin
         pend_d      = 1'b1;
         pend_page_d = src_page;
      end
      unique case (state_q)
         StIdle: begin
            if (start) begin
               page_d  = src_page;
               count_d = 8'h00;
               pend_d  = 1'b0;
               state_d = StArb;
            end
         end
         StArb:  state_d = StRdA;
         StRdA:  state_d = StRdB;
         StRdB:  state_d = StWrA;
         StWrA:  state_d = StWrB;
         StWrB: begin
            if (start || pend_q) begin
               page_d  = start ? src_page : pend_page_q;
               pend_d  = 1'b0;
               count_d = 8'h00;
               state_d = StRdA;
            end else if (count_q == 8'(LEN - 1)) begin
               state_d = StDone;
            end else begin
               count_d = count_q + 8'd1;
               state_d = StRdA;
            end
         end
         StDone: begin
            if (start) begin
               page_d  = src_page;
               count_d = 8'h00;
               state_d = StArb;
            end else begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Output values for the state about to be entered, so outputs are registered
   always_comb begin
      rd_d = (state_d == StRdA) || (state_d == StRdB);
      wr_d = (state_d == StWrA) || (state_d == StWrB);
      if (rd_d) begin
         addr_d = {eff_page(page_d), count_d};
      end else if (wr_d) begin
         addr_d = DST_BASE + {8'h00, count_d};
      end else begin
         addr_d = 16'h0000;
      end
   end

   // FSM state and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         count_q     <= 8'h00;
         page_q      <= 8'h00;
         pend_q      <= 1'b0;
         pend_page_q <= 8'h00;
         cpu_grant   <= 1'b1;
         busy        <= 1'b0;
         done        <= 1'b0;
         dma_addr    <= 16'h0000;
         addr_oe     <= 1'b0;
         data_oe     <= 1'b0;
         mem_cs      <= 1'b0;
         mem_oe      <= 1'b0;
         mem_we      <= 1'b0;
         dma_wdata   <= 8'h00;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         page_q      <= page_d;
         pend_q      <= pend_d;
         pend_page_q <= pend_page_d;
         cpu_grant   <= (state_d == StIdle);
         busy        <= (state_d != StIdle);
         done        <= (state_d == StDone);
         dma_addr    <= addr_d;
         addr_oe     <= rd_d || wr_d;
         data_oe     <= wr_d;
         mem_cs      <= rd_d || wr_d;
         mem_oe      <= rd_d;
         mem_we      <= (state_d == StWrB);
         if (state_q == StRdB) begin
            dma_wdata <= dma_rdata;
         end
      end
   end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Randomized bench for oam_dma_ctrl with a transfer-level reference model.
module tb_oam_dma_ctrl;

   localparam int unsigned LEN = 160;
   localparam logic [15:0] DST = 16'hFE00;

   logic        clk = 1'b0;
   logic        rst, start, start1;
   logic [7:0]  src_page, src_page1;
   logic        cpu_grant, busy, done, addr_oe, data_oe, mem_cs, mem_oe, mem_we;
   logic [15:0] dma_addr;
   logic [7:0]  dma_rdata, dma_wdata;
   logic        cpu_grant1, busy1, done1, addr_oe1, data_oe1, mem_cs1, mem_oe1, mem_we1;
   logic [15:0] dma_addr1;
   logic [7:0]  dma_rdata1, dma_wdata1;

   logic [7:0]  mem [0:65535];
   int          n_checks = 0;
   int          n_errors = 0;

   always #5 clk = ~clk;

   assign dma_rdata  = mem[dma_addr];
   assign dma_rdata1 = mem[dma_addr1];

   oam_dma_ctrl #(.LEN(LEN), .DST_BASE(DST)) u_dut (
      .clk(clk), .rst(rst), .start(start), .src_page(src_page),
      .cpu_grant(cpu_grant), .busy(busy), .done(done), .dma_addr(dma_addr),
      .addr_oe(addr_oe), .dma_rdata(dma_rdata), .dma_wdata(dma_wdata),
      .data_oe(data_oe), .mem_cs(mem_cs), .mem_oe(mem_oe), .mem_we(mem_we)
   );

   oam_dma_ctrl #(.LEN(1), .DST_BASE(DST)) u_one (
      .clk(clk), .rst(rst), .start(start1), .src_page(src_page1),
      .cpu_grant(cpu_grant1), .busy(busy1), .done(done1), .dma_addr(dma_addr1),
      .addr_oe(addr_oe1), .dma_rdata(dma_rdata1), .dma_wdata(dma_wdata1),
      .data_oe(data_oe1), .mem_cs(mem_cs1), .mem_oe(mem_oe1), .mem_we(mem_we1)
   );

   // Bus monitor: write log, busy/done accounting and ownership rules
   logic        log_clr = 1'b0;
   logic [15:0] wa [$];
   logic [7:0]  wd [$];
   int          busy_cnt, done_cnt, done_ok, viol = 0;
   logic        prev_done = 1'b0, prev_setup = 1'b0, rd_seen;
   logic [15:0] prev_addr = 16'h0, rd_first, rd_last;
   logic [15:0] wa1 [$];
   logic [7:0]  wd1 [$];
   int          busy1_cnt = 0;

   always @(posedge clk) begin
      if (log_clr) begin
         wa.delete();
         wd.delete();
         busy_cnt <= 0;
         done_cnt <= 0;
         done_ok  <= 0;
         rd_seen  <= 1'b0;
      end else begin
         if (mem_we && mem_cs) begin
            wa.push_back(dma_addr);
            wd.push_back(dma_wdata);
         end
         if (busy) busy_cnt <= busy_cnt + 1;
         if (done) done_cnt <= done_cnt + 1;
         if (prev_done && cpu_grant && !busy) done_ok <= done_ok + 1;
         if (mem_oe) begin
            if (!rd_seen) rd_first <= dma_addr;
            rd_seen <= 1'b1;
            rd_last <= dma_addr;
         end
      end
      if ((cpu_grant && (addr_oe || data_oe)) ||
          (mem_we && !(addr_oe && data_oe && mem_cs)) ||
          (mem_we && !(prev_setup && prev_addr == dma_addr)))
         viol <= viol + 1;
      prev_done  <= done;
      prev_setup <= data_oe && !mem_we;
      prev_addr  <= dma_addr;
      if (mem_we1) begin
         wa1.push_back(dma_addr1);
         wd1.push_back(dma_wdata1);
      end
      if (busy1) busy1_cnt <= busy1_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] eff(input logic [7:0] p);
      return (p >= 8'hE0) ? p - 8'h20 : p;
   endfunction

   task automatic clear_logs();
      @(negedge clk); log_clr = 1'b1;
      @(negedge clk); log_clr = 1'b0;
   endtask

   task automatic pulse_start(input logic [7:0] p);
      @(negedge clk); src_page = p; start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (!cpu_grant && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("idle_timeout", {31'd0, cpu_grant}, 32'd1);
      @(negedge clk);
   endtask

   // One transfer, optionally restarted at byte k (ph=0: in RD_A, ph=1: in WR_B)
   task automatic run_xfer(input logic [7:0] p1, input bit rs, input int k, input bit ph,
                           input logic [7:0] p2);
      int          n;
      logic [7:0]  pf;
      logic [23:0] ea [$];
      logic        hit;
      clear_logs();
      pulse_start(p1);
      if (rs) begin
         n = 0;
         hit = 1'b0;
         while (n < 4000 && !hit) begin
            hit = ph ? (mem_we && dma_addr == DST + 16'(k))
                     : (mem_oe && dma_addr == {eff(p1), 8'(k)});
            if (!hit) begin
               @(negedge clk);
               n++;
            end
         end
         check("restart_hit", {31'd0, hit}, 32'd1);
         src_page = p2; start = 1'b1;
         @(negedge clk); start = 1'b0;
      end
      wait_idle(5000);
      pf = rs ? p2 : p1;
      if (rs) for (int i = 0; i <= k; i++) ea.push_back({DST + 16'(i), mem[{eff(p1), 8'(i)}]});
      for (int i = 0; i < int'(LEN); i++) ea.push_back({DST + 16'(i), mem[{eff(pf), 8'(i)}]});
      check("n_writes", wa.size(), ea.size());
      for (int i = 0; i < ea.size() && i < wa.size(); i++)
         check("write", {8'h0, wa[i], wd[i]}, {8'h0, ea[i]});
      check("busy_cycles", busy_cnt, 2 + 4 * ea.size());
      check("done_pulses", done_cnt, 1);
      check("grant_after_done", done_ok, 1);
   endtask

   logic [31:0] rst_vec;
   int          found;

   initial begin
      rst = 1'b1; start = 1'b0; start1 = 1'b0; src_page = 8'h00; src_page1 = 8'h00;
      for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
      for (int i = 0; i < 256; i++) mem[16'hC100 + 16'(i)] = 8'(i) ^ 8'h5A;
      repeat (3) @(negedge clk);
      rst_vec = {cpu_grant, busy, done, addr_oe, data_oe, mem_cs, mem_oe, mem_we,
                 dma_addr, dma_wdata};
      check("reset_state", rst_vec, {1'b1, 7'b0, 16'h0, 8'h0});
      rst = 1'b0;

      // Basic transfer
      run_xfer(8'hC1, 1'b0, 0, 1'b0, 8'h00);
      check("basic_last", {24'h0, wd[LEN-1]}, {24'h0, 8'h9F ^ 8'h5A});

      // Echo mapping
      run_xfer(8'hE3, 1'b0, 0, 1'b0, 8'h00);
      check("echo_first_rd", {16'h0, rd_first}, 32'h0000C300);
      check("echo_last_rd", {16'h0, rd_last}, 32'h0000C39F);

      // Restart in RD_A of byte 10, and in WR_B of the last byte
      run_xfer(8'hC0, 1'b1, 10, 1'b0, 8'hD0);
      run_xfer(8'hC5, 1'b1, LEN - 1, 1'b1, 8'hF1);

      // Reset during WR_A of byte 50
      clear_logs();
      pulse_start(8'hC2);
      found = 0;
      while (found < 4000 && !(data_oe && !mem_we && dma_addr == 16'hFE32)) begin
         @(negedge clk);
         found++;
      end
      check("rst_hit", {31'd0, found < 4000}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst_vec = {cpu_grant, busy, done, addr_oe, data_oe, mem_cs, mem_oe, mem_we,
                 dma_addr, dma_wdata};
      check("rst_mid_state", rst_vec, {1'b1, 7'b0, 16'h0, 8'h0});
      rst = 1'b0;
      repeat (3) @(negedge clk);
      found = 0;
      foreach (wa[i]) if (wa[i] == 16'hFE32) found++;
      check("rst_fe32_unwritten", found, 0);
      check("rst_n_writes", wa.size(), 50);
      check("rst_no_done", done_cnt, 0);
      run_xfer(8'hC2, 1'b0, 0, 1'b0, 8'h00);

      // Randomized transfers against the model
      for (int t = 0; t < 4; t++)
         run_xfer(8'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(0, LEN - 1)),
                  1'($urandom_range(0, 1)), 8'($urandom));

      // Random start storm for bus-ownership rules
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         start = ($urandom_range(0, 63) == 0);
         src_page = 8'($urandom);
      end
      start = 1'b0;
      wait_idle(5000);
      check("bus_rules", viol, 0);

      // LEN=1 build
      @(negedge clk); src_page1 = 8'hC0; start1 = 1'b1;
      @(negedge clk); start1 = 1'b0;
      repeat (20) @(negedge clk);
      check("len1_writes", wa1.size(), 1);
      if (wa1.size() == 1) check("len1_write", {8'h0, wa1[0], wd1[0]}, {8'h0, 16'hFE00, mem[16'hC000]});
      check("len1_busy", busy1_cnt, 6);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/oam_dma_ctrl.md
Name: oam_dma_ctrl

Overview:
- Sequences OAM DMA transfers: copies LEN bytes from a source page to object attribute memory at DST_BASE.
- Owns the shared memory bus while a transfer runs and stalls the CPU control FSM through a grant handshake.
- Sits beside the control FSM on addr_bus and data_bus. It is triggered by the CPU's write to the DMA register (0xFF46).

Parameters:
- LEN, 160, number of bytes per transfer; must be in 1..256.
- DST_BASE, 16'hFE00, destination base address; low byte must be 0.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; a write to the DMA register
- src_page  in  8  source high byte; sampled with start
- cpu_grant  out  1  1 = CPU control FSM may drive the bus; 0 = CPU must hold its state
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse at transfer end
- dma_addr  out  16  address driven onto addr_bus when addr_oe=1
- addr_oe  out  1  tri-state enable for dma_addr
- dma_rdata  in  8  data_bus read value
- dma_wdata  out  8  write data; driven onto data_bus when data_oe=1
- data_oe  out  1  tri-state enable for dma_wdata
- mem_cs  out  1  memory chip select
- mem_oe  out  1  memory output enable
- mem_we  out  1  memory write enable

Behaviour:
- Clock and reset: one clock, clk. Reset is rst, synchronous and active-high, sampled on the rising edge of clk.
- Reset values: cpu_grant=1; all other outputs 0; state IDLE; byte count 0; latched page 0.
- Reset while a transfer is running aborts it at that edge: no done pulse, no further writes.
- States: IDLE, ARB, RD_A, RD_B, WR_A, WR_B, DONE.
- IDLE:
  - cpu_grant=1; all bus outputs 0.
  - When start=1: latch src_page, clear count, go to ARB.
- ARB (one-cycle bus turnaround):
  - cpu_grant=0, busy=1, no enables asserted.
  - Next state: RD_A.
- RD_A:
  - dma_addr = {eff_page, count}; addr_oe=1, mem_cs=1, mem_oe=1.
  - Next state: RD_B.
- RD_B:
  - Same outputs as RD_A; dma_wdata <= dma_rdata at the end of the cycle.
  - Next state: WR_A.
- WR_A:
  - dma_addr = DST_BASE + count; addr_oe=1, data_oe=1, mem_cs=1, mem_we=0 (address/data setup).
  - Next state: WR_B.
- WR_B:
  - Same as WR_A but mem_we=1.
  - If count==LEN-1, go to DONE. Otherwise count <= count+1 and go to RD_A.
- DONE:
  - busy=1, cpu_grant=0, done=1, all enables 0.
  - Next state: IDLE; cpu_grant=1 from the following cycle.
- Timing: cpu_grant is low and busy is high for exactly 2+4*LEN cycles, starting the cycle after start is sampled. For LEN=160 this is 642 cycles.
- Effective source page (eff_page):
  - src_page 0xE0..0xFF (echo region) maps to src_page-0x20.
  - All other src_page values are used unchanged.
- count is 8 bits. Source addresses stay within one page and never carry into the high byte.
- start while busy:
  - Latch the new src_page.
  - Finish the current byte (through WR_B).
  - Then clear count and restart at RD_A with the new page, without passing through ARB or DONE. cpu_grant stays 0 throughout.
  - A restart request arriving in WR_B of the last byte restarts instead of going to DONE.
  - start in DONE is treated as a new transfer: DONE -> ARB.
- Bus ownership:
  - addr_oe and data_oe are never high while cpu_grant=1.
  - mem_we is never high without data_oe=1 and addr_oe=1.
- CPU interlock: the CPU FSM observes cpu_grant=0 and holds its state. This block does not monitor CPU activity.

Test Plan:
- Basic transfer: rst, then start with src_page=0xC1; memory C100..C19F = i^0x5A.
  -> FE00..FE9F hold i^0x5A.
  -> busy high for 642 cycles; done pulses once on the last busy cycle; cpu_grant returns 1 the cycle after.
- Echo mapping: src_page=0xE3 -> first read address 0xC300, last read address 0xC39F.
- Restart mid-transfer: start(0xC0); start(0xD0) asserted during the RD_A of byte 10.
  -> FE00..FE0A come from C000..C00A.
  -> Then FE00..FE9F are rewritten from D000..D09F.
  -> Exactly one done pulse.
- Reset mid-transfer: assert rst during WR_A of byte 50.
  -> Next cycle all outputs at reset values, cpu_grant=1, no done pulse.
  -> FE32 is unwritten; a later start performs a full, correct transfer.
- Bus exclusivity check, assertion-based over random start and src_page stimulus:
  -> addr_oe/data_oe are never high while cpu_grant=1.
  -> mem_we=1 only in WR_B.
- LEN=1 build: start(0xC0) -> exactly one write, C000 -> FE00; busy high for 6 cycles.
